pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; must be a multiple of STAGES.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline slices; each slice is WIDTH/STAGES bits.
REQ-003 SHALL have parameter CNT_W, default 16, width of the overflow event counter.
REQ-004 SHALL use one clock and an asynchronous active-low reset:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide the following data and control ports:
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  two's-complement operand A.
- b  input  WIDTH  two's-complement operand B.
- cin  input  1  carry-in.
- sat  input  1  mode: 0 = wrap, 1 = saturate; captured with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry-out of the MSB.
- ovf  output  1  signed overflow of the raw sum.
- ovf_cnt  output  CNT_W  count of accepted results with ovf=1.
- cnt_clr  input  1  synchronous clear of ovf_cnt.

Function
REQ-006 SHALL advance the whole pipeline on adv = !out_valid || out_ready, and SHALL drive in_ready = adv.
REQ-007 SHALL accept a beat when in_valid && in_ready.
REQ-008 SHALL have a latency of exactly STAGES cycles: a beat accepted at edge N appears at edge N+STAGES-1 with no stall, so out_valid is high in the cycle following it.
REQ-009 Stage k SHALL add slice k of a and b plus the carry registered from stage k-1. Stage 0 uses cin.
REQ-010 Stage k SHALL forward the unconsumed upper slices and the lower partial sums unchanged.
REQ-011 When adv=0, SHALL hold all stage registers, including valid bits. No beat is lost or duplicated under any out_ready pattern.
REQ-012 Bubbles (invalid stages) SHALL advance with the pipeline and are not collapsed.
REQ-013 Raw sum SHALL be (a + b + cin) mod 2^WIDTH, and cout SHALL be bit WIDTH of the full sum.
REQ-014 ovf SHALL be 1 iff a[MSB]==b[MSB] and raw_sum[MSB]!=a[MSB].
REQ-015 When sat=1 and ovf=1, sum SHALL be the most-negative value if a[MSB]=1 (0x80000000 at WIDTH=32), else the most-positive value (0x7FFFFFFF).
REQ-016 In all other cases sum SHALL equal raw sum.
REQ-017 cout and ovf SHALL always report the raw result, regardless of sat.
REQ-018 sum, cout and ovf SHALL stay stable while out_valid && !out_ready.
REQ-019 ovf_cnt SHALL increment by 1 on each output handshake (out_valid && out_ready) carrying ovf=1.
REQ-020 ovf_cnt SHALL saturate at all-ones.
REQ-021 cnt_clr SHALL take priority over a simultaneous increment, giving 0.
REQ-022 With STAGES=1, the block SHALL degenerate to a single registered adder with identical handshake rules.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf and ovf_cnt to 0, including mid-operation; in-flight beats are discarded.
REQ-024 in_ready SHALL be 1 during and after reset.
REQ-025 Data registers other than the outputs need not be reset.

Structure
REQ-026 Shared package adder_pkg SHALL hold the sat mode encodings (SAT_WRAP=0, SAT_CLAMP=1) and the overflow/saturation helper function, reused by the other adder blocks.
REQ-027 Sub-module adder_slice SHALL implement one stage: slice add with carry in/out plus an enable-gated register. The top instantiates STAGES copies in a generate loop.

Verification
REQ-028 WIDTH=32, STAGES=4: a=0x7FFFFFFF, b=0x00000001, cin=0, sat=0 -> sum=0x80000000, cout=0, ovf=1, out_valid exactly 4 cycles after acceptance; same with sat=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-029 a=0xFFFFFFFF, b=0x80000000, cin=0, sat=0 -> sum=0x7FFFFFFF, cout=1, ovf=1; sat=1 -> sum=0x80000000.
REQ-030 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0 (carry traverses all four slices); a=0x7FFFFFFF, b=0xFFFFFFFF -> sum=0x7FFFFFFE, cout=1, ovf=0.
REQ-031 Back-pressure: six back-to-back beats with out_ready low for 3 cycles mid-stream -> in_ready drops, all six results emerge in order with no loss or duplication, outputs stable while stalled.
REQ-032 Counter: 3 overflow beats accepted -> ovf_cnt=3; cnt_clr coincident with a 4th overflow handshake -> ovf_cnt=0; with CNT_W=2, 5 overflows -> ovf_cnt=3 (saturated).
REQ-033 rst_n pulsed low with 3 beats in flight -> out_valid=0 and ovf_cnt=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: saturation mode encodings and
// the signed-overflow / clamp decision helpers.
package adder_pkg;

  typedef enum logic {
    SAT_WRAP  = 1'b0,
    SAT_CLAMP = 1'b1
  } sat_mode_e;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic logic clamp_hit(input logic sat, input logic ovf);
    return (sat == SAT_CLAMP) && ovf;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One pipeline stage: adds slice K of the operands with the incoming carry and
// registers the partial result; the final stage also resolves overflow/clamp.
module adder_slice
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int K      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  input  logic             sat_in,
  output logic             v_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             sat_out,
  output logic             ovf_out
);

  localparam int SW    = WIDTH / STAGES;
  localparam bit FINAL = (K == STAGES - 1);

  logic [SW:0]      part;
  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] s_next;
  logic             ovf;

  assign part = {1'b0, a_in[K*SW +: SW]} + {1'b0, b_in[K*SW +: SW]} + {{SW{1'b0}}, c_in};

  always_comb begin
    ext         = '0;
    ext[SW-1:0] = part[SW-1:0];
  end

  // Upper bits of s_in are still zero here, so OR merges the new slice in.
  assign raw     = s_in | (ext << (K * SW));
  assign ovf     = signed_ovf(a_in[WIDTH-1], b_in[WIDTH-1], raw[WIDTH-1]);
  assign sat_val = {a_in[WIDTH-1], {(WIDTH-1){~a_in[WIDTH-1]}}};
  assign s_next  = (FINAL && clamp_hit(sat_in, ovf)) ? sat_val : raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out   <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      s_out   <= '0;
      c_out   <= 1'b0;
      sat_out <= 1'b0;
      ovf_out <= 1'b0;
    end else if (en) begin
      v_out   <= v_in;
      a_out   <= a_in;
      b_out   <= b_in;
      s_out   <= s_next;
      c_out   <= part[SW];
      sat_out <= sat_in;
      ovf_out <= FINAL ? ovf : 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-sliced pipelined adder with valid/ready flow control, optional
// saturation and a saturating overflow event counter.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  logic             adv;
  logic             v_s   [0:STAGES];
  logic [WIDTH-1:0] a_s   [0:STAGES];
  logic [WIDTH-1:0] b_s   [0:STAGES];
  logic [WIDTH-1:0] s_s   [0:STAGES];
  logic             c_s   [0:STAGES];
  logic             sat_s [0:STAGES];
  logic             ovf_s [0:STAGES-1];

  // The whole pipe moves in lockstep, bubbles included.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign v_s[0]   = in_valid;
  assign a_s[0]   = a;
  assign b_s[0]   = b;
  assign s_s[0]   = '0;
  assign c_s[0]   = cin;
  assign sat_s[0] = sat;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .K      (k)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .v_in    (v_s[k]),
      .a_in    (a_s[k]),
      .b_in    (b_s[k]),
      .s_in    (s_s[k]),
      .c_in    (c_s[k]),
      .sat_in  (sat_s[k]),
      .v_out   (v_s[k+1]),
      .a_out   (a_s[k+1]),
      .b_out   (b_s[k+1]),
      .s_out   (s_s[k+1]),
      .c_out   (c_s[k+1]),
      .sat_out (sat_s[k+1]),
      .ovf_out (ovf_s[k])
    );
  end

  assign out_valid = v_s[STAGES];
  assign sum       = s_s[STAGES];
  assign cout      = c_s[STAGES];
  assign ovf       = ovf_s[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard on the 4-stage instance,
// plus a 1-stage / 2-bit-counter instance for degenerate and saturation cases.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sat, out_valid, out_ready, cout, ovf, cnt_clr;
  logic [31:0] a, b, sum;
  logic [15:0] ovf_cnt;

  logic        s_in_valid, s_in_ready, s_cin, s_sat, s_out_valid, s_out_ready, s_cout, s_ovf, s_cnt_clr;
  logic [31:0] s_a, s_b, s_sum;
  logic [1:0]  s_ovf_cnt;

  pipelined_adder #(.WIDTH(32), .STAGES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sat(s_sat), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .ovf_cnt(s_ovf_cnt), .cnt_clr(s_cnt_clr)
  );

  int tests = 0;
  int fails = 0;
  int popped = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_item;

  // Reference: {sum, cout, ovf} from wide signed arithmetic.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic m);
    logic [32:0] full;
    longint      r;
    logic [31:0] s;
    logic        o;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    r = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    s = full[31:0];
    if (m && (r > 64'sd2147483647)) s = 32'h7FFF_FFFF;
    else if (m && (r < -64'sd2147483648)) s = 32'h8000_0000;
    return {s, full[32], o};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sat));
      if (out_valid && out_ready) begin
        tests++;
        popped++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_extra: got sum=%h cout=%b ovf=%b, none expected", sum, cout, ovf);
        end else begin
          exp_item = exp_q.pop_front();
          if ({sum, cout, ovf} !== exp_item) begin
            fails++;
            $display("FAIL scoreboard: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, exp_item[33:2], exp_item[1], exp_item[0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic send_one(input logic [31:0] x, input logic [31:0] y, input logic c,
                          input logic m, output int lat);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; cin = c; sat = m;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    tests += 5;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if ({sum, cout, ovf} !== 34'd0) begin fails++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b, expected 0", sum, cout, ovf); end
    if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL reset_ovf_cnt: got %0d, expected 0", ovf_cnt); end
    if (s_in_ready !== 1'b1) begin fails++; $display("FAIL reset_small_in_ready: got %b, expected 1", s_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] vb [6] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_one(va[i], vb[i], vc[i], vs[i], lat);
      tests++;
      if (lat != 4) begin
        fails++;
        $display("FAIL latency_vec%0d: got %0d cycles, expected 4", i, lat);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [33:0] held = '0;
    bit hold_v = 0, saw_stall = 0, accepted;
    int idx = 0, cyc = 0, stab_bad = 0, start;
    for (int i = 0; i < 6; i++) begin
      va[i] = (i % 2 == 0) ? 32'h7FFF_0000 + $urandom_range(0, 65535) : $urandom;
      vb[i] = (i % 2 == 0) ? 32'h0001_0000 + $urandom_range(0, 65535) : $urandom;
    end
    start = popped;
    while ((idx < 6 || exp_q.size() > 0) && cyc < 60) begin
      if (idx < 6) begin
        in_valid = 1'b1; a = va[idx]; b = vb[idx]; cin = idx[0]; sat = idx[1];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(cyc >= 4 && cyc < 7);
      @(negedge clk);
      if (!in_ready) saw_stall = 1;
      if (out_valid && !out_ready) begin
        if (hold_v && ({sum, cout, ovf} !== held)) stab_bad++;
        held = {sum, cout, ovf};
        hold_v = 1;
      end else begin
        hold_v = 0;
      end
      accepted = in_valid && in_ready;
      tick();
      if (accepted) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests += 3;
    if (popped - start != 6) begin fails++; $display("FAIL b2b_count: got %0d results, expected 6", popped - start); end
    if (!saw_stall) begin fails++; $display("FAIL b2b_in_ready: got in_ready never low, expected a drop"); end
    if (stab_bad != 0) begin fails++; $display("FAIL b2b_stable: got %0d changes while stalled, expected 0", stab_bad); end
  endtask

  task automatic test_counter();
    int n = 0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = (i == 2) ? 32'h0000_0005 : 32'h7FFF_FFFF;
      b = (i == 2) ? 32'h0000_0003 : 32'h0000_0001;
      cin = 1'b0; sat = 1'b0;
      if (i == 3) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      tick();
    end
    in_valid = 1'b0;
    drain();
    tests++;
    if (ovf_cnt !== 16'd3) begin fails++; $display("FAIL ovf_cnt_three: got %0d, expected 3", ovf_cnt); end
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sat = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tests += 2;
    if (n >= 20) begin fails++; $display("FAIL ovf_clr_timeout: got no out_valid in %0d cycles, expected one", n); end
    if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL ovf_cnt_clr_priority: got %0d, expected 0", ovf_cnt); end
  endtask

  task automatic test_cnt_sat();
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_a = 32'h7FFF_FFFF; s_b = 32'h0000_0001; s_cin = 1'b0; s_sat = i[0];
      tick();
      tests++;
      if (!s_out_valid || s_ovf !== 1'b1 || s_cout !== 1'b0 || s_sum !== (i[0] ? 32'h7FFF_FFFF : 32'h8000_0000)) begin
        fails++;
        $display("FAIL small_beat%0d: got valid=%b sum=%h ovf=%b cout=%b, expected valid=1 sum=%h ovf=1 cout=0",
                 i, s_out_valid, s_sum, s_ovf, s_cout, i[0] ? 32'h7FFF_FFFF : 32'h8000_0000);
      end
    end
    s_in_valid = 1'b0;
    tick();
    tests += 2;
    if (s_ovf_cnt !== 2'd3) begin fails++; $display("FAIL small_cnt_sat: got %0d, expected 3", s_ovf_cnt); end
    if (s_out_valid !== 1'b0) begin fails++; $display("FAIL small_drained: got out_valid=%b, expected 0", s_out_valid); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sat = 1'b0;
    tick();
    in_valid = 1'b0;
    drain();
    tests++;
    if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL pre_reset_cnt: got %0d, expected 1", ovf_cnt); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h1000_0000 * i; b = 32'h7FFF_FFFF; cin = 1'b1; sat = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b, expected 0", out_valid); end
    if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL mid_reset_cnt: got %0d, expected 0", ovf_cnt); end
    if ({sum, cout, ovf} !== 34'd0) begin fails++; $display("FAIL mid_reset_outputs: got sum=%h cout=%b ovf=%b, expected 0", sum, cout, ovf); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_in_ready: got %b, expected 1", in_ready); end
    exp_q.delete();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL stale_after_reset: got out_valid=1, expected 0"); end
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sat = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sat = 1'b0; s_out_ready = 1'b1; s_cnt_clr = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_counter();
    test_cnt_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
